// File: rtl/lcd_pkg.sv
// Shared definitions for the SPI LCD receive sink: ST7789 command codes,
// parser state encoding and the power-on address window.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PARAM    = 2'd1,
        ST_RAMWR_HI = 2'd2,
        ST_RAMWR_LO = 2'd3
    } parse_state_t;

    localparam int DEF_XS = 0;
    localparam int DEF_XE = 239;
    localparam int DEF_YS = 0;
    localparam int DEF_YE = 134;

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Byte receiver for the 4-wire LCD SPI link: synchronizes the serial inputs
// into the clk domain, detects rising spi_clk edges and assembles MSB-first
// bytes. A CS release with a partial byte pending raises frag_err.
module lcd_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_rs,
    input  logic       spi_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       byte_rs,
    output logic       frag_err
);

    // All four inputs share the same chain depth so they stay aligned.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   cs_s;
    logic                   rs_s;
    logic                   data_s;
    logic                   clk_rise;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign rs_s     = rs_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;

    // Input synchronizers plus the delayed clock copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            cs_sync   <= '1;
            rs_sync   <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], spi_rs};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            clk_prev  <= clk_s;
        end
    end

    // Shift register and bit counter; the eighth edge delivers the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            byte_rs    <= 1'b0;
            frag_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frag_err   <= 1'b0;
            if (cs_s) begin
                if (bit_cnt != 3'd0) begin
                    frag_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (clk_rise) begin
                shift <= {shift[5:0], data_s};
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shift, data_s};
                    byte_rs    <= rs_s;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_sink.sv
// Receive-side decoder for the write-only ST7789-style SPI LCD link.
// Parses command/parameter bytes, tracks the CASET/RASET window and emits
// one RGB565 pixel per RAMWR byte pair with auto-advancing coordinates.
// Optional build macro LCD_SPI_SINK_CRC_EN adds frame_crc, a CRC-16-CCITT
// over every pixel of a frame, latched when the frame completes.
import lcd_pkg::*;

module lcd_spi_sink #(
    parameter int COORD_W     = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_clk,
    input  logic               spi_cs,
    input  logic               spi_rs,
    input  logic               spi_data,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               sleep_out,
    output logic               display_on,
    output logic               frame_done,
    output logic               frag_err
`ifdef LCD_SPI_SINK_CRC_EN
    ,
    output logic [15:0]        frame_crc
`endif
);

    logic               byte_valid;
    logic [7:0]         rx_byte;
    logic               byte_rs;
    logic               is_cmd;
    logic               is_dat;
    parse_state_t       state;
    parse_state_t       state_next;
    logic [1:0]         param_idx;
    logic               param_row;
    logic [7:0]         param_hi;
    logic [COORD_W-1:0] param_start;
    logic [COORD_W-1:0] param_end;
    logic [COORD_W-1:0] xs, xe, ys, ye;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [7:0]         hi_byte;
    logic               x_wrap;
    logic               y_wrap;

    lcd_spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_rs     (spi_rs),
        .spi_data   (spi_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .byte_rs    (byte_rs),
        .frag_err   (frag_err)
    );

    assign is_cmd = byte_valid & ~byte_rs;
    assign is_dat = byte_valid & byte_rs;

    // ">=" rather than "==" so a degenerate window (start > end) wraps at once.
    assign x_wrap = (cur_x >= xe);
    assign y_wrap = (cur_y >= ye);

    // Final parameter byte completes the end coordinate, truncated to COORD_W.
    assign param_end = COORD_W'({param_hi, rx_byte});

    // Parser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a command byte always overrides the current state.
    always_comb begin
        state_next = state;
        if (is_cmd) begin
            case (rx_byte)
                CMD_CASET, CMD_RASET: state_next = ST_PARAM;
                CMD_RAMWR:            state_next = ST_RAMWR_HI;
                default:              state_next = ST_IDLE;
            endcase
        end else if (is_dat) begin
            case (state)
                ST_PARAM:    if (param_idx == 2'd3) state_next = ST_IDLE;
                ST_RAMWR_HI: state_next = ST_RAMWR_LO;
                ST_RAMWR_LO: state_next = ST_RAMWR_HI;
                default:     state_next = state;
            endcase
        end
    end

    // Command side effects, window parameters, cursor and pixel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            sleep_out   <= 1'b0;
            display_on  <= 1'b0;
            frame_done  <= 1'b0;
            param_idx   <= '0;
            param_row   <= 1'b0;
            param_hi    <= '0;
            param_start <= '0;
            xs          <= COORD_W'(DEF_XS);
            xe          <= COORD_W'(DEF_XE);
            ys          <= COORD_W'(DEF_YS);
            ye          <= COORD_W'(DEF_YE);
            cur_x       <= COORD_W'(DEF_XS);
            cur_y       <= COORD_W'(DEF_YS);
            hi_byte     <= '0;
        end else begin
            pix_valid  <= 1'b0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (is_cmd) begin
                cmd_valid <= 1'b1;
                cmd_code  <= rx_byte;
                param_idx <= '0;
                case (rx_byte)
                    CMD_CASET:   param_row  <= 1'b0;
                    CMD_RASET:   param_row  <= 1'b1;
                    CMD_RAMWR: begin
                        cur_x <= xs;
                        cur_y <= ys;
                    end
                    CMD_SLPOUT:  sleep_out  <= 1'b1;
                    CMD_SLPIN:   sleep_out  <= 1'b0;
                    CMD_DISPON:  display_on <= 1'b1;
                    CMD_DISPOFF: display_on <= 1'b0;
                    default: ;
                endcase
            end else if (is_dat) begin
                case (state)
                    ST_PARAM: begin
                        param_idx <= param_idx + 2'd1;
                        case (param_idx)
                            2'd0: param_hi    <= rx_byte;
                            2'd1: param_start <= COORD_W'({param_hi, rx_byte});
                            2'd2: param_hi    <= rx_byte;
                            default: begin
                                if (param_row) begin
                                    ys <= param_start;
                                    ye <= param_end;
                                end else begin
                                    xs <= param_start;
                                    xe <= param_end;
                                end
                            end
                        endcase
                    end
                    ST_RAMWR_HI: hi_byte <= rx_byte;
                    ST_RAMWR_LO: begin
                        pix_valid <= 1'b1;
                        pix_x     <= cur_x;
                        pix_y     <= cur_y;
                        pix_data  <= {hi_byte, rx_byte};
                        if (x_wrap) begin
                            cur_x <= xs;
                            if (y_wrap) begin
                                cur_y      <= ys;
                                frame_done <= 1'b1;
                            end else begin
                                cur_y <= cur_y + 1'b1;
                            end
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LCD_SPI_SINK_CRC_EN
    // CRC-16-CCITT (poly 0x1021), 16 pixel bits folded in MSB first.
    function automatic logic [15:0] crc16_pix(input logic [15:0] crc_in,
                                              input logic [15:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] crc_acc;
    logic [15:0] crc_next;

    assign crc_next = crc16_pix(crc_acc, {hi_byte, rx_byte});

    // Accumulate per pixel; restart on RAMWR and after each completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_acc   <= 16'hFFFF;
            frame_crc <= '0;
        end else if (is_cmd && rx_byte == CMD_RAMWR) begin
            crc_acc <= 16'hFFFF;
        end else if (is_dat && state == ST_RAMWR_LO) begin
            if (x_wrap && y_wrap) begin
                frame_crc <= crc_next;
                crc_acc   <= 16'hFFFF;
            end else begin
                crc_acc <= crc_next;
            end
        end
    end
`endif

endmodule

// File: doc/lcd_spi_sink.md
Name: lcd_spi_sink

Overview:
- Receive-side decoder for the 4-wire write-only SPI LCD link (SCLK, CS, RS/DC, MOSI) that the panel driver produces, ST7789 command subset.
- Reassembles bytes, parses commands and parameters, tracks the CASET/RASET address window, and emits one RGB565 pixel write per RAMWR data pair.
- Used as an on-chip loopback/verification sink and as a display-capture front end feeding a framebuffer.

Parameters:
- COORD_W, 9, width of column/row coordinates (covers 0..511).
- SYNC_STAGES, 2, synchronizer flops on each SPI input.

Ports:
- clk  in  1  system clock; SPI inputs oversampled on it.
- rst  in  1  synchronous active-high reset.
- spi_clk  in  1  LCD serial clock; data sampled on its rising edge.
- spi_cs  in  1  chip select, active low.
- spi_rs  in  1  0 = command byte, 1 = data byte.
- spi_data  in  1  serial data, MSB first.
- pix_valid  out  1  one-cycle strobe, pixel write.
- pix_x  out  COORD_W  column of pixel.
- pix_y  out  COORD_W  row of pixel.
- pix_data  out  16  RGB565, first byte = [15:8].
- cmd_valid  out  1  one-cycle strobe on every command byte.
- cmd_code  out  8  last command byte.
- sleep_out  out  1  1 after SLPOUT (0x11), 0 after SLPIN (0x10).
- display_on  out  1  1 after DISPON (0x29), 0 after DISPOFF (0x28).
- frame_done  out  1  one-cycle strobe when the pixel at (xe,ye) is written.
- frag_err  out  1  one-cycle strobe when CS rises mid-byte.

Behaviour:
- Reset: all outputs 0; window xs=0, xe=239, ys=0, ye=134; cursor at (xs,ys); parser IDLE; bit counter 0.
- Inputs pass through SYNC_STAGES flops; rising edge of spi_clk is detected from the synchronized copy. spi_clk frequency must be ≤ clk/4.
- On each detected rising edge with synced CS low: shift in spi_data and increment bit_cnt.
- At bit 8, the byte is complete. RS is the value sampled with bit 8. bit_cnt clears.
- CS high: bit_cnt clears. If bit_cnt was nonzero, pulse frag_err and discard the partial byte.
- Byte-to-output latency: at most 2 clk after the detected 8th edge.
- Parser states: IDLE, PARAM, RAMWR_HI, RAMWR_LO.
- Any command byte (RS=0), in any state:
  - pulse cmd_valid and latch cmd_code;
  - abort the current command;
  - discard a pending high pixel byte;
  - reset param_idx.
- Command byte dispatch:
  - 0x2A or 0x2B: go to PARAM.
  - 0x2C: reset cursor to (xs,ys), then go to RAMWR_HI.
  - 0x11, 0x10, 0x29, 0x28: update the status flag, then go to IDLE.
  - Any other command: go to IDLE, with its data bytes ignored.
- PARAM:
  - Bytes 0..3 form start[15:8], start[7:0], end[15:8], end[7:0]. Truncate to COORD_W.
  - After byte 3, commit start/end to the x or y window and go to IDLE.
  - Fewer than 4 params before the next command: no commit.
  - Extra params: ignored.
- RAMWR_HI: latch the data byte as the high byte, then go to RAMWR_LO.
- RAMWR_LO:
  - Form the pixel; pulse pix_valid with the current cursor; go to RAMWR_HI.
  - Cursor advance: x++; if x==xe, then x=xs and y++; if y==ye as well, y=ys and pulse frame_done in the same cycle as pix_valid.
  - Writes past the window therefore wrap to (xs,ys) and continue.
- Degenerate window: xs>xe or ys>ye makes that axis wrap immediately (x stays xs). Not an error.
- IDLE data bytes: ignored.
- Reset asserted mid-byte or mid-frame: immediate return to reset values; no pix_valid in that cycle.

Optional Feature:
- LCD_SPI_SINK_CRC_EN defined:
  - Adds output frame_crc[15:0], a CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pix_data of each pixel.
  - The value is latched to frame_crc on frame_done; the accumulator re-inits on RAMWR and after frame_done.
  - Reset value 0.
- Undefined: port and logic absent.

Decomposition:
- Shared package lcd_pkg:
  - command constants CMD_SLPIN 0x10, CMD_SLPOUT 0x11, CMD_DISPOFF 0x28, CMD_DISPON 0x29, CMD_CASET 0x2A, CMD_RASET 0x2B, CMD_RAMWR 0x2C;
  - parser state encoding;
  - default window 0..239 / 0..134.
- Sub-module lcd_spi_byte_rx: synchronizer, edge detect, shifter, frag_err; outputs byte_valid/byte/byte_rs.

Test Plan:
- Send cmd 0x11, then 0x29 → cmd_valid ×2, cmd_code 0x29, sleep_out=1, display_on=1.
- CASET 00 28 01 17, RASET 00 35 00 B4, RAMWR, data F8 00 → pix_valid once, pix_x=0x028, pix_y=0x035, pix_data=0xF800.
- Window x 2..3, y 5..6, RAMWR then 5 pixels → coords (2,5),(3,5),(2,6),(3,6) with frame_done on the 4th, then (2,5).
- Drop CS after 5 bits, then a full data pair → frag_err pulse; only the complete bytes form the pixel.
- RAMWR, data 0xAB, then cmd 0x2C, data 12 34 → single pixel 0x1234 at (xs,ys).
- Assert rst mid-RAMWR → all outputs 0, window restored to 0..239/0..134.
